// File: rtl/mem_req_arbiter_if.sv
// Processor request/response and memory port bundle for mem_req_arbiter.
// slave is the arbiter's view; master is the processors-plus-memory side.
interface mem_req_arbiter_if #(
    parameter int N_PROC = 4,
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
);
    logic [N_PROC-1:0]        proc_req;
    logic [N_PROC-1:0]        proc_we;
    logic [N_PROC*ADDR_W-1:0] proc_addr;
    logic [N_PROC*DATA_W-1:0] proc_wdata;
    logic [N_PROC-1:0]        proc_gnt;
    logic [N_PROC-1:0]        proc_done;
    logic [DATA_W-1:0]        proc_rdata;
    logic                     mem_read_req;
    logic                     mem_write_req;
    logic [ADDR_W-1:0]        mem_addr;
    logic [DATA_W-1:0]        mem_write_data;
    logic [DATA_W-1:0]        mem_read_data;

    modport slave (
        input  proc_req, proc_we, proc_addr, proc_wdata, mem_read_data,
        output proc_gnt, proc_done, proc_rdata,
               mem_read_req, mem_write_req, mem_addr, mem_write_data
    );

    modport master (
        output proc_req, proc_we, proc_addr, proc_wdata, mem_read_data,
        input  proc_gnt, proc_done, proc_rdata,
               mem_read_req, mem_write_req, mem_addr, mem_write_data
    );
endinterface

// File: rtl/mem_req_arbiter.sv
// Round-robin serialiser of N_PROC processor requests onto one memory port.
// One transaction in flight: IDLE -> ISSUE -> (WAIT) -> RESP -> IDLE.
module mem_req_arbiter #(
    parameter int N_PROC     = 4,
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    mem_req_arbiter_if.slave   bus
);
    localparam int ID_W  = (N_PROC > 1) ? $clog2(N_PROC) : 1;
    localparam int CNT_W = 3;
    localparam logic [N_PROC-1:0] ONE = N_PROC'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t state, state_nxt;

    logic [N_PROC-1:0][ADDR_W-1:0] addr_a;
    logic [N_PROC-1:0][DATA_W-1:0] wdata_a;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  cnt;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   idx;

    assign addr_a  = bus.proc_addr;
    assign wdata_a = bus.proc_wdata;

    // first requester at or after rr_ptr, wrapping modulo N_PROC
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = 0; k < N_PROC; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_PROC);
            if (!win_vld && bus.proc_req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (win_vld) state_nxt = ISSUE;
            ISSUE: state_nxt = we_q ? RESP : WAIT;
            WAIT:  if (cnt == CNT_W'(1)) state_nxt = RESP;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.proc_gnt       = '0;
        bus.proc_done      = '0;
        bus.mem_read_req   = 1'b0;
        bus.mem_write_req  = 1'b0;
        bus.mem_addr       = addr_q;
        bus.mem_write_data = wdata_q;
        bus.proc_rdata     = rdata_q;
        case (state)
            ISSUE: begin
                bus.proc_gnt      = ONE << id_q;
                bus.mem_write_req = we_q;
                bus.mem_read_req  = !we_q;
            end
            RESP: bus.proc_done = ONE << id_q;
            default: ;
        endcase
    end

    // addr/wdata are latched at the IDLE edge and simply held afterwards,
    // which gives the ISSUE values and the hold-last-value behaviour together
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            id_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    id_q    <= win_id;
                    we_q    <= bus.proc_we[win_id];
                    addr_q  <= addr_a[win_id];
                    wdata_q <= wdata_a[win_id];
                end
                ISSUE: cnt <= CNT_W'(RD_LATENCY);
                WAIT: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) rdata_q <= bus.mem_read_data;
                end
                RESP: rr_ptr <= (id_q == ID_W'(N_PROC - 1)) ? '0 : id_q + ID_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
`define CK(t, o, e) chk(t, 32'(o), 32'(e))

module tb_mem_req_arbiter;
  localparam int N  = 4;
  localparam int AW = 14;
  localparam int DW = 16;
  localparam logic [N-1:0] ONE = 4'b0001;

  typedef struct {
    logic [1:0]    id;
    logic          we;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_clr;
  logic [N-1:0] req3;
  always #5 clk = ~clk;

  mem_req_arbiter_if #(.N_PROC(N), .ADDR_W(AW), .DATA_W(DW)) if1 ();
  mem_req_arbiter_if #(.N_PROC(N), .ADDR_W(AW), .DATA_W(DW)) if3 ();

  mem_req_arbiter #(.N_PROC(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1));
  mem_req_arbiter #(.N_PROC(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .bus(if3));

  assign if3.proc_req   = req3;
  assign if3.proc_we    = if1.proc_we;
  assign if3.proc_addr  = if1.proc_addr;
  assign if3.proc_wdata = if1.proc_wdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rd1;
  logic [DW-1:0] d3 [0:2];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else begin
      if (if1.mem_write_req) mem[if1.mem_addr] <= if1.mem_write_data;
      if (if3.mem_write_req) mem[if3.mem_addr] <= if3.mem_write_data;
    end
    rd1   <= if1.mem_read_req ? mem[if1.mem_addr] : 16'hDEAD;
    d3[0] <= if3.mem_read_req ? mem[if3.mem_addr] : 16'hDEAD;
    d3[1] <= d3[0];
    d3[2] <= d3[1];
  end
  assign if1.mem_read_data = rd1;
  assign if3.mem_read_data = d3[2];

  int errors = 0;
  int checks = 0;
  exp_t sbq[$];
  logic [DW-1:0] refm [0:(1<<AW)-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (reset === 1'b0) begin
      checks++;
      if ((if1.mem_read_req & if1.mem_write_req) !== 1'b0) begin
        errors++;
        $error("FAIL strobe_excl");
      end
      checks++;
      if ((if1.mem_read_req | if1.mem_write_req) !== (|if1.proc_gnt)) begin
        errors++;
        $error("FAIL strobe_only_with_gnt: rd=%b wr=%b gnt=%b",
               if1.mem_read_req, if1.mem_write_req, if1.proc_gnt);
      end
      checks++;
      if ($countones(if1.proc_gnt) > 1) begin
        errors++;
        $error("FAIL gnt_onehot: gnt=%b", if1.proc_gnt);
      end
      if (|if1.proc_done) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_done: done=%b", if1.proc_done);
        end else begin
          e = sbq.pop_front();
          checks++;
          if (if1.proc_done !== (ONE << e.id)) begin
            errors++;
            $error("FAIL done_id: got %b expected %b", if1.proc_done, ONE << e.id);
          end
          if (!e.we) begin
            checks++;
            if (if1.proc_rdata !== e.rdata) begin
              errors++;
              $error("FAIL rdata: got %h expected %h", if1.proc_rdata, e.rdata);
            end
          end
        end
      end
    end
  end

  task automatic push(input logic [1:0] p, input logic we, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    exp_t e;
    if1.proc_we[p]             = we;
    if1.proc_addr[p*AW +: AW]  = a;
    if1.proc_wdata[p*DW +: DW] = d;
    e.id    = p;
    e.we    = we;
    e.rdata = we ? '0 : refm[a];
    if (we) refm[a] = d;
    sbq.push_back(e);
  endtask

  task automatic do_txn(input logic [1:0] p, input logic we, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    int n;
    bit got;
    @(negedge clk);
    push(p, we, a, d);
    if1.proc_req = ONE << p;
    n = 0; got = 0;
    while (n < 10 && !got) begin
      @(negedge clk); n++;
      if (|if1.proc_gnt) got = 1;
    end
    `CK("gnt_lat", n, 1);
    `CK("gnt", if1.proc_gnt, ONE << p);
    `CK("wr_req", if1.mem_write_req, we);
    `CK("rd_req", if1.mem_read_req, !we);
    `CK("mem_addr", if1.mem_addr, a);
    `CK("mem_wdata", if1.mem_write_data, d);
    if1.proc_req = '0;
    n = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk); n++;
      if (|if1.proc_done) got = 1;
    end
    `CK("done_lat", n, we ? 1 : 2);
  endtask

  task automatic group(input logic [N-1:0] mask, input logic [2*N-1:0] order);
    int n, k;
    @(negedge clk);
    if1.proc_req = mask;
    n = 0; k = 0;
    while (n < 60 && k < $countones(mask)) begin
      @(negedge clk); n++;
      if (|if1.proc_gnt) begin
        `CK("grp_gnt", if1.proc_gnt, ONE << order[k*2 +: 2]);
        k++;
      end
      if (|if1.proc_done) if1.proc_req = if1.proc_req & ~if1.proc_done;
    end
    `CK("grp_count", k, $countones(mask));
    while (n < 60 && |if1.proc_req) begin
      @(negedge clk); n++;
      if (|if1.proc_done) if1.proc_req = if1.proc_req & ~if1.proc_done;
    end
    `CK("grp_drained", if1.proc_req, 0);
  endtask

  task automatic chk_zero(input string pfx);
    `CK({pfx, "_gnt"}, if1.proc_gnt, 0);
    `CK({pfx, "_done"}, if1.proc_done, 0);
    `CK({pfx, "_rdata"}, if1.proc_rdata, 0);
    `CK({pfx, "_rd"}, if1.mem_read_req, 0);
    `CK({pfx, "_wr"}, if1.mem_write_req, 0);
    `CK({pfx, "_addr"}, if1.mem_addr, 0);
    `CK({pfx, "_wdata"}, if1.mem_write_data, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    int n;
    reset = 1'b1; mem_clr = 1'b1; req3 = '0;
    if1.proc_req = '0; if1.proc_we = '0; if1.proc_addr = '0; if1.proc_wdata = '0;
    for (int i = 0; i < (1 << AW); i++) refm[i] = '0;

    repeat (2) begin
      @(negedge clk);
      if1.proc_req   = 4'($urandom);
      if1.proc_we    = 4'($urandom);
      if1.proc_addr  = 56'({$urandom, $urandom});
      if1.proc_wdata = {$urandom, $urandom};
      req3           = 4'($urandom);
    end
    @(negedge clk);
    chk_zero("rst");
    `CK("rst3_gnt", if3.proc_gnt, 0);
    `CK("rst3_strobes", {if3.mem_read_req, if3.mem_write_req}, 0);
    if1.proc_req = '0; req3 = '0; mem_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    do_txn(2'd2, 1'b1, 14'h0123, 16'hBEEF);

    do_txn(2'd1, 1'b0, 14'h0123, 16'h0000);
    @(negedge clk);
    if1.proc_we[1] = 1'b0;
    if1.proc_addr[1*AW +: AW] = 14'h0123;
    req3 = 4'b0010;
    n = 0;
    while (n < 20 && !(|if3.proc_done)) begin
      @(negedge clk); n++;
      if (n == 1) begin
        `CK("l3_gnt", if3.proc_gnt, 4'b0010);
        `CK("l3_rd_req", if3.mem_read_req, 1);
        req3 = '0;
      end
    end
    `CK("l3_done_lat", n, 5);
    `CK("l3_done", if3.proc_done, 4'b0010);
    `CK("l3_rdata", if3.proc_rdata, 16'hBEEF);
    @(negedge clk);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("rst2_pre");
    reset = 1'b0;
    push(2'd0, 1'b1, 14'h0040, 16'h1111);
    push(2'd1, 1'b0, 14'h0040, 16'h0000);
    push(2'd2, 1'b1, 14'h0041, 16'h2222);
    push(2'd3, 1'b0, 14'h0041, 16'h0000);
    group(4'b1111, {2'd3, 2'd2, 2'd1, 2'd0});

    push(2'd0, 1'b1, 14'h0050, 16'h3333);
    push(2'd3, 1'b0, 14'h0050, 16'h0000);
    group(4'b1001, {2'd0, 2'd0, 2'd3, 2'd0});

    @(negedge clk);
    if1.proc_we[1] = 1'b0;
    if1.proc_addr[1*AW +: AW] = 14'h0050;
    if1.proc_req = 4'b0010;
    @(negedge clk);
    `CK("abort_gnt", if1.proc_gnt, 4'b0010);
    if1.proc_req = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("abort");
    reset = 1'b0;
    do_txn(2'd1, 1'b1, 14'h0200, 16'hA5A5);

    for (int t = 0; t < 1000; t++) begin
      logic [AW-1:0] a;
      a = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 31)) : 14'($urandom);
      do_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, 16'($urandom));
    end

    repeat (3) @(negedge clk);
    `CK("sb_empty", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
